// File: rtl/spram_arb_ctrl.sv
// Two-requester round-robin arbiter and read-tag sequencer for one single-port RAM.
// Define SPRAM_ARB_CTRL_INIT_EN to zero-fill the RAM after reset before accepting traffic.
module spram_arb_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16,
  parameter int RD_LAT     = 2,
  localparam int AW        = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [AW-1:0]         req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [AW-1:0]         req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  ram_wea,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_re_data,
  output logic                  init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

`ifdef SPRAM_ARB_CTRL_INIT_EN
  localparam state_e RST_STATE = ST_INIT;
  logic [AW-1:0] cnt_q, cnt_d;
`else
  localparam state_e RST_STATE = ST_RUN;
`endif

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    init_done_q, init_done_d;
  logic [AW-1:0]           addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  tag_t [RD_LAT-1:0]       tag_q, tag_d;
  tag_t                    push;
  tag_t                    head;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    ram_wea      = 1'b0;
    ram_addr     = addr_q;
    ram_wr_data  = wdata_q;
    push         = '0;
`ifdef SPRAM_ARB_CTRL_INIT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef SPRAM_ARB_CTRL_INIT_EN
        ram_wea     = 1'b1;
        ram_addr    = cnt_q;
        ram_wr_data = '0;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == AW'(DATA_DEPTH - 1)) state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        // last_grant_q == 1 means requester 0 wins a tie, and vice versa.
        req0_ready = req0_valid & (~req1_valid | last_grant_q);
        req1_ready = req1_valid & (~req0_valid | ~last_grant_q);
        if (req0_ready) begin
          ram_wea      = req0_we;
          ram_addr     = req0_addr;
          ram_wr_data  = req0_wdata;
          last_grant_d = 1'b0;
          push         = '{vld: ~req0_we, id: 1'b0};
        end else if (req1_ready) begin
          ram_wea      = req1_we;
          ram_addr     = req1_addr;
          ram_wr_data  = req1_wdata;
          last_grant_d = 1'b1;
          push         = '{vld: ~req1_we, id: 1'b1};
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      ram_wea    = 1'b0;
    end
  end

  always_comb begin
    tag_d[0] = push;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    init_done_d = (state_d == ST_RUN);
  end

  assign head       = tag_q[RD_LAT-1];
  assign rsp0_valid = head.vld & ~head.id;
  assign rsp1_valid = head.vld & head.id;
  assign rsp0_data  = ram_re_data;
  assign rsp1_data  = ram_re_data;
  assign init_done  = init_done_q;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      last_grant_q <= 1'b1;
      init_done_q  <= (RST_STATE == ST_RUN);
      addr_q       <= '0;
      wdata_q      <= '0;
      tag_q        <= '0;
`ifdef SPRAM_ARB_CTRL_INIT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      init_done_q  <= init_done_d;
      addr_q       <= ram_addr;
      wdata_q      <= ram_wr_data;
      tag_q        <= tag_d;
`ifdef SPRAM_ARB_CTRL_INIT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_spram_arb_ctrl.sv
// Self-checking bench for spram_arb_ctrl: table vectors, corner sequences and random traffic
// against a transaction-level model (round-robin rule, word array, expected-response queue).
module tb_spram_arb_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic          ram_wea;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_re_data;
  logic          init_done;

  spram_arb_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_re_data(ram_re_data), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Single-port RAM: input register stage, then registered read output.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [AW-1:0] ram_a_r;
  logic          ram_we_r;
  logic [DW-1:0] ram_wd_r;
  initial begin
    ram_a_r = '0; ram_we_r = 1'b0; ram_wd_r = '0; ram_re_data = '0;
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = DW'(8'hC3 ^ i);
  end
  always @(posedge clk) begin
    ram_a_r  <= ram_addr;
    ram_we_r <= ram_wea;
    ram_wd_r <= ram_wr_data;
    if (ram_we_r) ram_mem[ram_a_r] <= ram_wd_r;
    ram_re_data <= ram_mem[ram_a_r];
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          id;
    logic [DW-1:0] data;
    int          due;
  } exp_t;

  typedef struct {
    bit v0; bit we0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    bit v1; bit we1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    bit r0; bit r1; bit wea; logic [AW-1:0] addr;
  } vec_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_last;
  int            m_init_left;
  bit            m_prev_known;
  logic [AW-1:0] m_prev_addr;
  logic [DW-1:0] m_prev_wdata;
  bit            acc0, acc1;
  int            cyc;
  int            n_cmp, n_bad;
  vec_t          tbl[12];
  vec_t          nov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drv(input bit v0, input bit we0, input int a0, input int d0,
                     input bit v1, input bit we1, input int a1, input int d1);
    req0_valid = v0; req0_we = we0; req0_addr = AW'(a0); req0_wdata = DW'(d0);
    req1_valid = v1; req1_we = we1; req1_addr = AW'(a1); req1_wdata = DW'(d1);
  endtask

  task automatic model_reset();
    m_last       = 1'b1;
    m_prev_known = 1'b0;
    acc0         = 1'b1;
    acc1         = 1'b1;
    exp_q.delete();
`ifdef SPRAM_ARB_CTRL_INIT_EN
    m_init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
`else
    m_init_left = 0;
`endif
  endtask

  // One clock cycle: compare outputs at the falling edge, then advance the model.
  task automatic step(input bit use_tbl, input vec_t tv);
    bit e0, e1, g0, g1, we;
    logic [DW-1:0] ed, wd;
    logic [AW-1:0] a;
    @(negedge clk);
    e0 = 1'b0; e1 = 1'b0; ed = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e0 = !exp_q[0].id;
      e1 = exp_q[0].id;
      ed = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    check("rsp0_valid", rsp0_valid, e0);
    check("rsp1_valid", rsp1_valid, e1);
    if (e0) check("rsp0_data", rsp0_data, ed);
    if (e1) check("rsp1_data", rsp1_data, ed);
    acc0 = 1'b0; acc1 = 1'b0;
    if (m_init_left > 0) begin
      check("init_done_low", init_done, 0);
      check("init_ready0", req0_ready, 0);
      check("init_ready1", req1_ready, 0);
      check("init_wea", ram_wea, 1);
      check("init_addr", ram_addr, DEPTH - m_init_left);
      check("init_wdata", ram_wr_data, 0);
      m_prev_known = 1'b1;
      m_prev_addr  = AW'(DEPTH - m_init_left);
      m_prev_wdata = '0;
      m_init_left--;
    end else begin
      check("init_done", init_done, 1);
      g0 = req0_valid && (!req1_valid || m_last);
      g1 = req1_valid && (!req0_valid || !m_last);
      check("req0_ready", req0_ready, g0);
      check("req1_ready", req1_ready, g1);
      if (g0 || g1) begin
        we = g0 ? req0_we : req1_we;
        a  = g0 ? req0_addr : req1_addr;
        wd = g0 ? req0_wdata : req1_wdata;
        check("ram_wea", ram_wea, we);
        check("ram_addr", ram_addr, a);
        check("ram_wr_data", ram_wr_data, wd);
        if (we) m_mem[a] = wd;
        else    exp_q.push_back('{id: g1, data: m_mem[a], due: cyc + LAT});
        m_last = g1;
        m_prev_known = 1'b1; m_prev_addr = a; m_prev_wdata = wd;
        acc0 = g0; acc1 = g1;
      end else begin
        check("idle_wea", ram_wea, 0);
        if (m_prev_known) begin
          check("hold_addr", ram_addr, m_prev_addr);
          check("hold_wdata", ram_wr_data, m_prev_wdata);
        end
      end
      if (use_tbl) begin
        check("tbl_ready0", req0_ready, tv.r0);
        check("tbl_ready1", req1_ready, tv.r1);
        check("tbl_wea", ram_wea, tv.wea);
        check("tbl_addr", ram_addr, tv.addr);
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step(0, nov);
  endtask

  // Reset with both requesters asserting valid; neither may be accepted nor write the RAM.
  task automatic reset_and_init(input int n);
    rst_n = 1'b0;
    drv(1, 1, 3, 8'hEE, 1, 1, 4, 8'hDD);
    model_reset();
    repeat (n) begin
      @(negedge clk);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_wea", ram_wea, 0);
      cyc++;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SPRAM_ARB_CTRL_INIT_EN
    repeat (DEPTH) step(0, nov);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pv0, pv1;
    n_cmp = 0; n_bad = 0; cyc = 0;
    nov = '{default: '0};
    for (int i = 0; i < DEPTH; i++) m_mem[i] = DW'(8'hC3 ^ i);

    //         v0 we0 a0 d0      v1 we1 a1 d1      r0 r1 wea addr
    tbl[0]  = '{1, 0, 1, 8'h00,  1, 0, 2, 8'h00,   1, 0, 0, 1};
    tbl[1]  = '{1, 0, 1, 8'h00,  1, 0, 2, 8'h00,   0, 1, 0, 2};
    tbl[2]  = '{1, 0, 1, 8'h00,  1, 0, 2, 8'h00,   1, 0, 0, 1};
    tbl[3]  = '{1, 0, 1, 8'h00,  1, 0, 2, 8'h00,   0, 1, 0, 2};
    tbl[4]  = '{0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 2};
    tbl[5]  = '{0, 0, 0, 8'h00,  1, 1, 9, 8'h33,   0, 1, 1, 9};
    tbl[6]  = '{1, 1, 4, 8'h44,  1, 1, 5, 8'h55,   1, 0, 1, 4};
    tbl[7]  = '{0, 0, 0, 8'h00,  1, 1, 5, 8'h55,   0, 1, 1, 5};
    tbl[8]  = '{1, 0, 4, 8'h00,  1, 0, 9, 8'h00,   1, 0, 0, 4};
    tbl[9]  = '{0, 0, 0, 8'h00,  1, 0, 9, 8'h00,   0, 1, 0, 9};
    tbl[10] = '{0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 9};
    tbl[11] = '{0, 0, 0, 8'h00,  0, 0, 0, 8'h00,   0, 0, 0, 9};

    @(posedge clk); #1;
    reset_and_init(3);

`ifdef SPRAM_ARB_CTRL_INIT_EN
    // Zero-filled RAM: read of addr 5 returns 0.
    drv(1, 0, 5, 0, 0, 0, 0, 0);
    step(0, nov);
    idle(3);
`endif

    // First cycle of RUN: write 0xA5 to addr 3, read it back next cycle.
    drv(1, 1, 3, 8'hA5, 0, 0, 0, 0);
    step(0, nov);
    drv(1, 0, 3, 0, 0, 0, 0, 0);
    step(0, nov);
    idle(4);

    // Table vectors from a fresh reset (requester 0 wins the first tie).
    reset_and_init(2);
    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
      step(1, tbl[i]);
    end
    idle(2);

    // Round-robin contention on pre-written words.
    reset_and_init(2);
    drv(1, 1, 1, 8'h11, 1, 1, 2, 8'h22);
    step(0, nov);
    drv(0, 0, 0, 0, 1, 1, 2, 8'h22);
    step(0, nov);
    drv(1, 0, 1, 0, 1, 0, 2, 0);
    repeat (4) step(0, nov);
    // Write and read of the same word collide; write wins, read sees new data.
    drv(1, 1, 7, 8'h5A, 1, 0, 7, 0);
    step(0, nov);
    drv(0, 0, 0, 0, 1, 0, 7, 0);
    step(0, nov);
    idle(4);

    // Reset the cycle after a read is accepted: its response must never appear.
    drv(1, 0, 3, 0, 0, 0, 0, 0);
    step(0, nov);
    reset_and_init(1);
    idle(6);

    // Random traffic honouring the hold-until-accepted rule.
    pv0 = 1'b0; pv1 = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (!(pv0 && !acc0)) begin
        pv0 = ($urandom_range(0, 99) < 65);
        req0_we = $urandom_range(0, 1); req0_addr = AW'($urandom_range(0, 7));
        req0_wdata = DW'($urandom);
      end
      if (!(pv1 && !acc1)) begin
        pv1 = ($urandom_range(0, 99) < 65);
        req1_we = $urandom_range(0, 1); req1_addr = AW'($urandom_range(0, 7));
        req1_wdata = DW'($urandom);
      end
      req0_valid = pv0; req1_valid = pv1;
      step(0, nov);
    end
    idle(4);
    check("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spram_arb_ctrl.md
Name: spram_arb_ctrl

Overview:
- Two-requester arbiter and sequencer in front of one single-port RAM instance.
- The RAM registers addr/wea/wr_data internally, then registers re_data.
- The block shares the RAM port round-robin, tags each accepted read and returns its data to the owning requester after the fixed RAM read latency.
- Optionally zero-fills the RAM after reset before accepting traffic.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- DATA_DEPTH, 16, RAM word count. Power of two, ≥2. AW = $clog2(DATA_DEPTH).
- RD_LAT, 2, cycles from the RAM-port drive cycle to valid ram_re_data. Fixed by the RAM: 1 input register + 1 output register.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset. Synchronous, active-low.
- req0_valid  in  1  requester 0 request valid
- req0_ready  out  1  requester 0 accepted this cycle
- req0_we  in  1  1 = write, 0 = read
- req0_addr  in  AW  word address
- req0_wdata  in  DATA_WIDTH  write data
- rsp0_valid  out  1  read data valid for requester 0
- rsp0_data  out  DATA_WIDTH  read data for requester 0
- req1_valid / req1_ready / req1_we / req1_addr / req1_wdata / rsp1_valid / rsp1_data: same as requester 0, for requester 1.
- ram_wea  out  1  to RAM wea
- ram_addr  out  AW  to RAM addr
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data
- ram_re_data  in  DATA_WIDTH  from RAM re_data
- init_done  out  1  high once the controller is in RUN

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - state=INIT, init counter=0, last_grant=1 (so requester 0 wins the first tie), init_done=0.
  - Both response-tag shift registers cleared, so rsp0_valid=rsp1_valid=0.
  - reqN_ready=0 and ram_wea=0 while in reset.
- Reset mid-operation abandons in-flight reads: no rsp is ever issued for them.
- States:
  - INIT: ram_wea=1, ram_addr=init counter, ram_wr_data=0, both ready=0. Counter increments each cycle. After address DATA_DEPTH-1 is issued, go to RUN.
  - RUN: arbitrate every cycle. Stays in RUN until reset.
- Arbitration (RUN, combinational on the current valids):
  - Only one valid: grant it.
  - Both valid: grant the requester ≠ last_grant.
  - None valid: no grant, ram_wea=0, ram_addr/ram_wr_data hold their previous values.
  - reqN_ready = grant to N. A transfer occurs when reqN_valid & reqN_ready. last_grant updates only on a transfer.
- RAM drive: in the transfer cycle T, ram_wea/ram_addr/ram_wr_data are driven combinationally from the granted request. At most one RAM operation per cycle. Full throughput: 1 op/cycle.
- Read response:
  - A read accepted in cycle T pushes tag {valid=1, id=N} into an RD_LAT-deep shift register.
  - In cycle T+RD_LAT the tag is at the head: rspN_valid=1 for exactly one cycle and rspN_data=ram_re_data. The other rsp_valid is 0.
  - rspN_data is don't-care when rspN_valid=0.
  - Responses cannot be back-pressured.
  - Writes push tag valid=0 and produce no response.
- Ordering: responses are in acceptance order. Back-to-back reads from either requester return on consecutive cycles.
- Same-address write then read, in cycles T and T+1: the read returns the new data.
- Requester rules: reqN_* must stay stable while valid && !ready. Dropping valid before acceptance withdraws the request without side effects.
- init_done = (state==RUN), registered.

Optional Feature:
- Macro SPRAM_ARB_CTRL_INIT_EN.
- Defined: the INIT zero-fill described above runs. It takes DATA_DEPTH cycles after reset release. init_done rises on the following cycle; first acceptance is possible in cycle DATA_DEPTH+1 after reset release.
- Undefined: reset state is RUN. No zero-fill, the init counter is not built, and init_done=1 on the first cycle after reset release. RAM contents are whatever the RAM itself initialises to.

Test Plan:
- Init sweep (macro on, depth 16): release reset -> ram_wea=1 with addresses 0..15 and data 0 on 16 consecutive cycles, then init_done=1. Afterwards, a read of addr 5 from requester 0 -> rsp0_valid 2 cycles after acceptance with data 0x00.
- Single-requester write/read: req0 writes 0xA5 to addr 3, then reads addr 3 the next cycle -> rsp0_data=0xA5 exactly 2 cycles after read acceptance; rsp1_valid stays 0.
- Round-robin contention: both requesters hold valid reads (req0 addr 1, req1 addr 2, pre-written 0x11/0x22) for 4 cycles -> grants alternate 0,1,0,1. Responses alternate rsp0=0x11 and rsp1=0x22 on 4 consecutive cycles, each 2 cycles after its grant.
- Mixed traffic: req0 write 0x5A to addr 7 while req1 reads addr 7 in the same cycle -> req0 granted first, req1 one cycle later; rsp1_data=0x5A.
- Reset mid-flight: accept a read, assert rst_n=0 the next cycle -> no rsp_valid ever appears for that read, and (macro on) the INIT sweep restarts from addr 0.
- Macro off: release reset -> init_done=1 on the first cycle and a request is accepted in that cycle.
